// File: rtl/hatch_sequencer.sv
// hatch_sequencer: egg-hatch timeline for the 8x8 dot-matrix display driver.
// Steps the frame index once per TICKS_PER_STAGE clocks while the incubator
// temperature is in range. It holds on pause or cold and flags completion.
// Optional feature macro: HATCH_COLD_ABORT_EN (abort after COLD_LIMIT
// consecutive cold cycles in RUN/HOLD). Undefined by default.
//
// state | meaning
// IDLE  | waiting for start, display blank
// RUN   | counting ticks, advancing one frame per stage period
// HOLD  | timeline frozen by pause or cold sensor
// DONE  | last frame shown, waiting for restart
// FAIL  | aborted on prolonged cold (HATCH_COLD_ABORT_EN only)
module hatch_sequencer #(
  parameter int TICKS_PER_STAGE = 1000,
  parameter int LAST_FRAME      = 11,
  parameter int COLD_LIMIT      = 5000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic       i_pause,
  input  logic       i_temp_ok,
  output logic [3:0] o_num,
  output logic       o_temp,
  output logic       o_st,
  output logic       o_done,
  output logic       o_fail
);

  localparam logic [15:0] TICK_LAST = 16'(TICKS_PER_STAGE - 1);
  localparam logic [3:0]  NUM_LAST  = 4'(LAST_FRAME);

  // Reject out-of-range parameters at elaboration.
  if (TICKS_PER_STAGE < 2 || TICKS_PER_STAGE > 65535) begin : g_bad_ticks
    $error("hatch_sequencer: TICKS_PER_STAGE out of range 2..65535");
  end
  if (LAST_FRAME < 1 || LAST_FRAME > 15) begin : g_bad_last
    $error("hatch_sequencer: LAST_FRAME out of range 1..15");
  end
  if (COLD_LIMIT < 1 || COLD_LIMIT > 65536) begin : g_bad_cold
    $error("hatch_sequencer: COLD_LIMIT out of range 1..65536");
  end

`ifdef HATCH_COLD_ABORT_EN
  typedef enum logic [2:0] {S_IDLE, S_RUN, S_HOLD, S_DONE, S_FAIL} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HOLD, S_DONE} state_t;
`endif

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_tick;
  logic [15:0] w_tick_nxt;
  logic [3:0]  r_num;
  logic [3:0]  w_num_nxt;
  logic        r_sync1;
  logic        r_sync2;
  logic        w_tok;

  assign w_tok = r_sync2;
  assign o_num = r_num;

  // Two-flop synchroniser for the asynchronous temperature sensor level.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= i_temp_ok;
      r_sync2 <= r_sync1;
    end
  end

`ifdef HATCH_COLD_ABORT_EN
  localparam logic [15:0] COLD_LAST = 16'(COLD_LIMIT - 1);

  logic [15:0] r_cold;
  logic [15:0] w_cold_nxt;
  logic        w_cold_active;
  logic        w_cold_abort;

  // Consecutive-cold counter, only live while the timeline is in progress.
  always_comb begin
    w_cold_active = ((r_state == S_RUN) || (r_state == S_HOLD)) && !w_tok;
    w_cold_abort  = w_cold_active && (r_cold == COLD_LAST);
    w_cold_nxt    = (w_cold_active && !w_cold_abort) ? r_cold + 16'd1 : 16'd0;
  end

  // Cold counter register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cold <= 16'd0;
    end else begin
      r_cold <= w_cold_nxt;
    end
  end
`endif

  // Next-state, tick and frame logic; a freeze request beats a rollover.
  always_comb begin
    w_state_nxt = r_state;
    w_tick_nxt  = r_tick;
    w_num_nxt   = r_num;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_state_nxt = S_RUN;
          w_tick_nxt  = 16'd0;
          w_num_nxt   = 4'd0;
        end
      end
      S_RUN: begin
`ifdef HATCH_COLD_ABORT_EN
        if (w_cold_abort) begin
          w_state_nxt = S_FAIL;
        end else
`endif
        if (i_pause || !w_tok) begin
          w_state_nxt = S_HOLD;
        end else if (r_tick == TICK_LAST) begin
          w_tick_nxt = 16'd0;
          if (r_num == NUM_LAST) begin
            w_state_nxt = S_DONE;
          end else begin
            w_num_nxt = r_num + 4'd1;
          end
        end else begin
          w_tick_nxt = r_tick + 16'd1;
        end
      end
      S_HOLD: begin
`ifdef HATCH_COLD_ABORT_EN
        if (w_cold_abort) begin
          w_state_nxt = S_FAIL;
        end else
`endif
        if (!i_pause && w_tok) begin
          w_state_nxt = S_RUN;
        end
      end
      default: begin
        // DONE and FAIL: only a new start leaves.
        if (i_start) begin
          w_state_nxt = S_RUN;
          w_tick_nxt  = 16'd0;
          w_num_nxt   = 4'd0;
        end
      end
    endcase
  end

  // State, counter and registered display outputs, decoded from the next state.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_tick  <= 16'd0;
      r_num   <= 4'd0;
      o_st    <= 1'b0;
      o_done  <= 1'b0;
      o_temp  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_tick  <= w_tick_nxt;
      r_num   <= w_num_nxt;
      o_st    <= (w_state_nxt != S_IDLE);
      o_done  <= (w_state_nxt == S_DONE);
      if (w_state_nxt == S_IDLE) begin
        o_temp <= 1'b0;
`ifdef HATCH_COLD_ABORT_EN
      end else if (w_state_nxt == S_FAIL) begin
        o_temp <= 1'b1;
`endif
      end else begin
        o_temp <= ~w_tok;
      end
    end
  end

`ifdef HATCH_COLD_ABORT_EN
  // Registered abort flag.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_fail <= 1'b0;
    end else begin
      o_fail <= (w_state_nxt == S_FAIL);
    end
  end
`else
  assign o_fail = 1'b0;
`endif

endmodule

// File: tb/tb_hatch_sequencer.sv
// Bench for hatch_sequencer: directed timeline scenarios plus random stimulus,
// all checked every cycle against a progress-based model of the timeline.
module tb_hatch_sequencer;

  localparam int T = 4;
  localparam int L = 11;
  localparam int C = 10;
`ifdef HATCH_COLD_ABORT_EN
  localparam bit ABORT = 1'b1;
`else
  localparam bit ABORT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic       temp_ok = 1'b1;
  logic [3:0] o_num;
  logic       o_temp, o_st, o_done, o_fail;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  hatch_sequencer #(
    .TICKS_PER_STAGE(T),
    .LAST_FRAME(L),
    .COLD_LIMIT(C)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_start(start),
    .i_pause(pause),
    .i_temp_ok(temp_ok),
    .o_num(o_num),
    .o_temp(o_temp),
    .o_st(o_st),
    .o_done(o_done),
    .o_fail(o_fail)
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: the timeline is a count of productive cycles. The frame is that
  // count divided by the stage length; completion is (L+1)*T productive cycles.
  // A cycle spent frozen makes the following resume cycle unproductive.
  bit m_s1 = 1'b1, m_s2 = 1'b1, m_tok;
  bit m_active = 1'b0, m_held = 1'b0, m_done = 1'b0, m_fail = 1'b0, m_temp = 1'b0;
  int m_prog = 0;
  int m_cold = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_s1 = 1'b1; m_s2 = 1'b1;
      m_active = 1'b0; m_held = 1'b0; m_done = 1'b0; m_fail = 1'b0;
      m_temp = 1'b0; m_prog = 0; m_cold = 0;
    end else begin
      m_tok = m_s2;
      m_s2 = m_s1;
      m_s1 = temp_ok;
      if (!m_active || m_done || m_fail) begin
        m_cold = 0;
        if (start) begin
          m_active = 1'b1; m_held = 1'b0; m_done = 1'b0; m_fail = 1'b0;
          m_prog = 0;
        end
      end else if (ABORT && !m_tok && m_cold == C - 1) begin
        m_fail = 1'b1;
        m_cold = 0;
      end else begin
        m_cold = m_tok ? 0 : m_cold + 1;
        if (pause || !m_tok) m_held = 1'b1;
        else if (m_held) m_held = 1'b0;
        else begin
          m_prog++;
          if (m_prog == (L + 1) * T) m_done = 1'b1;
        end
      end
      if (!m_active) m_temp = 1'b0;
      else if (m_fail) m_temp = 1'b1;
      else m_temp = !m_tok;
    end
  end

  function automatic int exp_num();
    int f;
    f = m_prog / T;
    if (f > L) f = L;
    return m_active ? f : 0;
  endfunction

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("num", 16'(o_num), 16'(exp_num()));
      check("st", 16'(o_st), 16'(m_active));
      check("done", 16'(o_done), 16'(m_done));
      check("fail", 16'(o_fail), 16'(m_fail));
      check("temp", 16'(o_temp), 16'(m_temp));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  initial begin
    int k;
    #1 rst = 1'b1;
    cyc(2);
    chk_en = 1'b1;
    check("rst_num", 16'(o_num), 16'd0);
    check("rst_st", 16'(o_st), 16'd0);
    rst = 1'b0;
    cyc(3);
    check("idle_wait_st", 16'(o_st), 16'd0);

    // Nominal run: num steps every T cycles, done after (L+1)*T cycles.
    pulse_start();
    check("start_st", 16'(o_st), 16'd1);
    check("start_num", 16'(o_num), 16'd0);
    k = 0;
    while (!o_done && k < 60) begin
      cyc(1);
      k++;
      if (k == 20) check("nominal_num20", 16'(o_num), 16'd5);
    end
    check("done_latency", 16'(k), 16'd48);
    check("done_num", 16'(o_num), 16'(L));

    // Asynchronous reset mid-run with num=5.
    pulse_start();
    cyc(20);
    check("pre_rst_num", 16'(o_num), 16'd5);
    #2 rst = 1'b1;
    #1;
    check("async_rst_num", 16'(o_num), 16'd0);
    check("async_rst_st", 16'(o_st), 16'd0);
    cyc(1);
    rst = 1'b0;
    cyc(4);
    check("post_rst_idle", 16'(o_st), 16'd0);

    // Pause for 7 cycles at tick 2.
    pulse_start();
    cyc(2);
    pause = 1'b1;
    cyc(7);
    check("pause_frozen", 16'(o_num), 16'd0);
    pause = 1'b0;
    cyc(1);
    check("resume_plus1", 16'(o_num), 16'd0);
    cyc(1);
    check("resume_plus2_pre", 16'(o_num), 16'd0);
    cyc(1);
    check("resume_advance", 16'(o_num), 16'd1);

    // Pause on the rollover cycle.
    cyc(3);
    pause = 1'b1;
    cyc(1);
    check("pause_rollover", 16'(o_num), 16'd1);
    pause = 1'b0;
    cyc(1);
    check("rollover_resume", 16'(o_num), 16'd1);
    cyc(1);
    check("rollover_advance", 16'(o_num), 16'd2);

    // Cold hold.
    temp_ok = 1'b0;
    cyc(2);
    check("cold_temp_2", 16'(o_temp), 16'd0);
    cyc(1);
    check("cold_temp_3", 16'(o_temp), 16'd1);
    check("cold_num", 16'(o_num), 16'd2);
    cyc(6);
    check("cold_hold_num", 16'(o_num), 16'd2);
    temp_ok = 1'b1;
    cyc(3);
    check("warm_temp", 16'(o_temp), 16'd0);
    cyc(2);
    check("warm_advance", 16'(o_num), 16'd3);

    // Prolonged cold.
    temp_ok = 1'b0;
    cyc(14);
`ifdef HATCH_COLD_ABORT_EN
    check("abort_fail", 16'(o_fail), 16'd1);
    check("abort_num", 16'(o_num), 16'd3);
    temp_ok = 1'b1;
    pulse_start();
    check("restart_fail", 16'(o_fail), 16'd0);
    check("restart_num", 16'(o_num), 16'd0);
`else
    check("noabort_fail", 16'(o_fail), 16'd0);
    check("noabort_num", 16'(o_num), 16'd3);
    temp_ok = 1'b1;
    cyc(3);
    check("noabort_temp", 16'(o_temp), 16'd0);
    cyc(2);
    check("noabort_advance", 16'(o_num), 16'd4);
`endif

    // Randomized stimulus, checked every cycle by the model.
    for (int i = 0; i < 3000; i++) begin
      start = ($urandom_range(0, 39) == 0);
      pause = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 24) == 0) temp_ok = ~temp_ok;
      if ($urandom_range(0, 599) == 0) begin
        #2 rst = 1'b1;
        cyc(1);
        rst = 1'b0;
      end else begin
        cyc(1);
      end
    end

    start = 1'b0;
    pause = 1'b0;
    cyc(2);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
